// File: rtl/mycpu_div.sv
// ============================================================================
// Module   : mycpu_div
// Purpose  : Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for EX.
//            Optional macro MYCPU_DIV_ZERO_FAST_EN: zero divisor skips iterations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mycpu_div (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    input  logic        div_ack,
    input  logic        div_cancel,
    output logic        div_stop,
    output logic        div_done,
    output logic [31:0] div_q,
    output logic [31:0] div_r,
    output logic        div_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [63:0] prem;
    logic [31:0] abs_b;
    logic [31:0] raw_a;
    logic        q_neg;
    logic        r_neg;
    logic        b_zero;

    logic        accept;
    logic        zero_fast;
    logic [31:0] abs_a;
    logic [31:0] abs_b_in;
    logic [32:0] diff;
    logic [63:0] prem_nxt;
    logic [31:0] q_raw;
    logic [31:0] r_raw;

    assign abs_a    = (div_signed && div_a[31]) ? (32'd0 - div_a) : div_a;
    assign abs_b_in = (div_signed && div_b[31]) ? (32'd0 - div_b) : div_b;

    // Top 33 bits of the shifted partial remainder against the divisor;
    // bit 32 of the difference is the borrow.
    assign diff     = prem[63:31] - {1'b0, abs_b};
    assign prem_nxt = diff[32] ? {prem[62:0], 1'b0}
                               : {diff[31:0], prem[30:0], 1'b1};
    assign q_raw    = prem_nxt[31:0];
    assign r_raw    = prem_nxt[63:32];

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_fast = 1'b0;
        if (div_cancel) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_start) begin
                        accept = 1'b1;
`ifdef MYCPU_DIV_ZERO_FAST_EN
                        if (div_b == 32'd0) begin
                            zero_fast = 1'b1;
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_BUSY;
                        end
`else
                        state_nxt = S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (cnt == 5'd31) state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (div_ack) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= 5'd0;
            prem   <= 64'd0;
            abs_b  <= 32'd0;
            raw_a  <= 32'd0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
            div_q  <= 32'd0;
            div_r  <= 32'd0;
        end else if (accept) begin
            cnt    <= 5'd0;
            prem   <= {32'd0, abs_a};
            abs_b  <= abs_b_in;
            raw_a  <= div_a;
            q_neg  <= div_signed & (div_a[31] ^ div_b[31]);
            r_neg  <= div_signed & div_a[31];
            b_zero <= (div_b == 32'd0);
            if (zero_fast) begin
                div_q <= 32'hFFFF_FFFF;
                div_r <= div_a;
            end
        end else if (state == S_BUSY && !div_cancel) begin
            prem <= prem_nxt;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                div_q <= b_zero ? 32'hFFFF_FFFF : (q_neg ? (32'd0 - q_raw) : q_raw);
                div_r <= b_zero ? raw_a         : (r_neg ? (32'd0 - r_raw) : r_raw);
            end
        end
    end

    // Gated by resetn so the stall request also drops during reset.
    assign div_stop = resetn & ~div_cancel &
                      (((state == S_IDLE) & div_start) | (state == S_BUSY));
    assign div_done = (state == S_DONE);
    assign div_busy = (state == S_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_mycpu_div.sv
// ============================================================================
// Module   : tb_mycpu_div
// Purpose  : Directed self-checking bench for mycpu_div with arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mycpu_div;

`ifdef MYCPU_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_ack;
    logic        div_cancel;
    logic        div_stop;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q  = 32'd0;
    logic [31:0] exp_r  = 32'd0;

    mycpu_div dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_ack    (div_ack),
        .div_cancel (div_cancel),
        .div_stop   (div_stop),
        .div_done   (div_done),
        .div_q      (div_q),
        .div_r      (div_r),
        .div_busy   (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural MIPS result: truncating division, remainder has dividend sign.
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    always @(negedge clk) begin
        if (resetn && div_done) begin
            chk("model_q", div_q, exp_q);
            chk("model_r", div_r, exp_r);
        end
    end

    // Called at posedge+1 of the cycle the divide is presented (cycle 0).
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int stall, input logic [31:0] lq, input logic [31:0] lr);
        int lat;
        lat = (FAST && b == 32'd0) ? 1 : 33;
        model(sgn, a, b, exp_q, exp_r);
        div_signed = sgn;
        div_a      = a;
        div_b      = b;
        div_start  = 1'b1;
        for (int k = 0; k <= lat + stall; k++) begin
            @(negedge clk);
            chk("stop", {31'd0, div_stop}, {31'd0, k < lat});
            chk("busy", {31'd0, div_busy}, {31'd0, (k >= 1) && (k < lat)});
            chk("done", {31'd0, div_done}, {31'd0, k >= lat});
            if (k == lat) begin
                chk("lit_q", div_q, lq);
                chk("lit_r", div_r, lr);
            end
            if (k == lat + stall) div_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        div_start = 1'b0;
        div_ack   = 1'b0;
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle_stop", {31'd0, div_stop}, 32'd0);
        chk("idle_busy", {31'd0, div_busy}, 32'd0);
        chk("idle_done", {31'd0, div_done}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_a      = 32'd0;
        div_b      = 32'd0;
        div_ack    = 1'b0;
        div_cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", div_q, 32'd0);
        chk("rst_r", div_r, 32'd0);
        chk("rst_flags", {29'd0, div_stop, div_done, div_busy}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_div(1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2);
        check_idle();

        // Back-to-back: next divide presented in the IDLE cycle after div_ack.
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 32'd1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 32'h8000_0000);
        run_div(1'b0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FF9C);
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 32'd14, 32'hFFFF_FFFE);

        // MEM stall: DONE held three extra cycles with div_start still high.
        run_div(1'b0, 32'd1000, 32'd3, 3, 32'd333, 32'd1);
        check_idle();

        // Cancel at cycle 10 with div_start dropped.
        div_signed = 1'b0;
        div_a      = 32'd12345;
        div_b      = 32'd10;
        div_start  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        div_cancel = 1'b1;
        div_start  = 1'b0;
        @(negedge clk);
        chk("cancel_stop", {31'd0, div_stop}, 32'd0);
        @(posedge clk);
        #1;
        div_cancel = 1'b0;
        @(negedge clk);
        chk("cancel_idle", {29'd0, div_stop, div_done, div_busy}, 32'd0);
        chk("cancel_q_kept", div_q, 32'd333);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_done) seen = 1'b1;
        end
        chk("cancel_no_done", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;

        // Async reset at cycle 20 of a divide; div_start stays asserted.
        div_signed = 1'b0;
        div_a      = 32'h0000_FFFF;
        div_b      = 32'h0000_0010;
        div_start  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, div_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_q", div_q, 32'd0);
        chk("arst_r", div_r, 32'd0);
        chk("arst_flags", {29'd0, div_stop, div_done, div_busy}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        run_div(1'b0, 32'h0000_FFFF, 32'h0000_0010, 0, 32'h0000_0FFF, 32'h0000_000F);
        check_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mycpu_div.md
# mycpu_div

Iterative 32-bit radix-2 restoring divider in the execute stage of the five-stage MIPS pipeline. Accepts a DIV/DIVU issued by EX, holds EX through `div_stop` (which drives the hazard unit's stall-E decision) while it iterates, then presents quotient (to LO) and remainder (to HI) until EX hands the instruction to MEM. It is cancellable by exception/ERET flush.

## Interface
- No parameters; operand width fixed at 32.
- `clk` input 1: single clock, all state on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `div_start` input 1: EX holds a valid DIV/DIVU (`es_valid` & div op); level, held until `div_ack`.
- `div_signed` input 1: 1 = DIV, 0 = DIVU; sampled with operands.
- `div_a` input 32: dividend (rs), sampled on accept.
- `div_b` input 32: divisor (rt), sampled on accept.
- `div_ack` input 1: EX instruction leaves EX this cycle (`es_ready_go && ms_allowin`).
- `div_cancel` input 1: flush of EX (exception/ERET); highest priority.
- `div_stop` output 1: stall request to hazard unit; combinational.
- `div_done` output 1: `div_q`/`div_r` valid.
- `div_q` output 32: quotient, to LO.
- `div_r` output 32: remainder, to HI.
- `div_busy` output 1: state is BUSY (debug/perf counter).

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE, counter 0, `div_q`=`div_r`=0, `div_done`=0, `div_busy`=0.
- IDLE: `div_start` & !`div_cancel` -> latch |a|, |b| (abs only if `div_signed`), sign of quotient (a[31]^b[31])&signed, sign of remainder a[31]&signed, divisor-zero flag, raw `div_a`; counter=0; -> BUSY.
- BUSY: per cycle shift 64-bit partial remainder left 1, trial-subtract {1'b0,|b|} from top 33 bits; non-negative -> keep difference, quotient bit 1; else quotient bit 0. Counter +1; after 32nd iteration (counter 31) -> DONE with sign-corrected results registered.
- Sign correction: q negated if quotient sign set; r negated if remainder sign set (remainder takes dividend's sign).
- Divisor zero: results forced to q=32'hFFFF_FFFF, r=raw `div_a`, both signed and unsigned.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: q=0x8000_0000, r=0 (falls out of abs/negate on 32 bits; no special case).
- DONE: `div_done`=1, outputs stable; `div_ack` -> IDLE. Results keep last value in IDLE; `div_done`=0 outside DONE.
- `div_stop` = !`div_cancel` & ((IDLE & `div_start`) | BUSY).
- `div_cancel` in any state -> IDLE next edge; `div_done` cleared; `div_q`/`div_r` unchanged.
- `div_start` in DONE is ignored (same instruction); re-accept only from IDLE, so back-to-back divides cost one IDLE cycle after `div_ack`.
- `div_ack` outside DONE ignored.

## Timing
- Cycle 0: IDLE, `div_start`=1 -> `div_stop`=1 same cycle (no bubble leaks past EX).
- Cycles 1-32: BUSY, `div_stop`=1, `div_busy`=1.
- Cycle 33: DONE, `div_stop`=0, `div_done`=1; EX may advance same cycle.
- `div_stop` high for exactly 33 cycles per normal divide; DONE lasts until `div_ack` (>=1 cycle if MEM stalls).
- Async reset mid-BUSY: all outputs 0 immediately, IDLE; a still-asserted `div_start` after release restarts from cycle 0.

## Configuration
- `MYCPU_DIV_ZERO_FAST_EN` defined: divisor zero detected in IDLE goes directly IDLE -> DONE; `div_stop` high only in cycle 0, `div_done` in cycle 1; forced zero-divisor results.
- Undefined: zero divisor runs full 32 iterations (DONE at cycle 33), same forced results. Nonzero divisors identical in both builds.

## Test plan
- DIVU 100/7, `div_ack` at DONE -> `div_stop` high cycles 0-32, cycle 33 `div_done`=1, q=14, r=2, IDLE at cycle 34.
- DIV -7/2 and 7/-2 -> q=0xFFFF_FFFD, r=0xFFFF_FFFF; then q=0xFFFF_FFFD, r=1.
- DIV 0x8000_0000/0xFFFF_FFFF -> q=0x8000_0000, r=0; DIVU same operands -> q=0, r=0x8000_0000.
- DIVU 5/0 -> q=0xFFFF_FFFF, r=5; done at cycle 1 with `MYCPU_DIV_ZERO_FAST_EN`, cycle 33 without.
- `div_cancel` at cycle 10, `div_start` dropped -> `div_stop` 0 same cycle, IDLE cycle 11, `div_done` never asserts; `resetn` low at cycle 20 of another divide -> outputs 0 asynchronously.
- DONE with `div_ack` low 3 cycles (MEM stall), `div_start` held -> results stable, no restart; next divide presented the cycle after `div_ack` accepted one cycle later.
